mutex_arbiter: RTL
==================

# mutex_arbiter

Hardware mutual-exclusion arbiter that grants a single shared critical resource to one of N requesting processes at a time. Each process raises a level request, holds the resource while granted, and returns it with a release pulse or by dropping its request. A rotating turn pointer gives round-robin fairness. A hold-time watchdog forcibly revokes a grant that is held too long. The block sits between the process state machines and the shared resource; its grant vector is the only enable into the critical section.

## Interface
- N, default 4: number of requesters, legal range 2..8.
- MAX_HOLD, default 200: maximum number of consecutive cycles a grant may be held; legal range 2..255.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  per-process level request; bit i is high while process i wants or holds the resource.
- rel  input  N  per-process single-cycle release pulse.
- grant  output  N  one-hot (or zero) grant vector, registered.
- owner  output  clog2(N)  index of the current or most recent grantee.
- busy  output  1  high while the state is GRANTED.
- turn  output  clog2(N)  round-robin search start index.
- timeout  output  1  single-cycle pulse when the watchdog revokes a grant.
- violation  output  1  sticky flag; set if popcount(grant) > 1 is ever registered.

## Operation
- The state machine has three states: FREE, GRANTED and RELEASE.
- **FREE**
  - If any req bit is high, select the first set bit searching upward from turn, wrapping modulo N.
  - Next cycle: grant[sel]=1, owner=sel, hold_cnt=0, state GRANTED.
  - If no req bit is high, stay in FREE.
- **GRANTED**
  - hold_cnt increments by 1 each cycle. It is an 8-bit counter and saturates, so it never wraps.
  - Release condition: rel[owner]=1 or req[owner]=0. When met, go to RELEASE.
  - Watchdog: if hold_cnt == MAX_HOLD-1 and the release condition is false, go to RELEASE and pulse timeout for one cycle.
  - If the release condition and the watchdog condition occur in the same cycle, release wins and timeout stays 0.
  - rel or req changes on non-owner bits are ignored while GRANTED. Their requests remain pending.
- **RELEASE**
  - grant=0 and turn = (owner+1) mod N.
  - The next state is always FREE.
  - owner keeps its value.
- Fairness: a process that holds req continuously is granted before any other process is granted twice. Equivalently, it waits at most N-1 other grants.
- violation is set when a registered grant has more than one bit set. It stays set until reset. It must never fire in a correct implementation.
- **Reset** (asynchronous, any state): state=FREE, grant=0, owner=0, turn=0, busy=0, timeout=0, violation=0, hold_cnt=0. A grant in progress is dropped immediately when reset_n falls.

## Timing
- Request latency, FREE: req[i] sampled high at edge t gives grant[i]=1 after edge t. The first grant cycle is t+1.
- Release latency: rel[owner] sampled at edge t gives grant=0 and turn updated after edge t. State is FREE after edge t+1.
- Minimum gap between grants: 2 cycles, covering the RELEASE cycle and the FREE decision cycle. A waiting requester is granted after edge t+2 following the release edge t.
- Maximum hold: grant stays high for exactly MAX_HOLD cycles when no release occurs. timeout is high during the first cycle that grant is 0.
- busy equals |grant registered in the same cycle.
- Search arbitration is combinational within the FREE cycle. All outputs are registered.

## Test plan
- **Reset:** hold reset_n=0 with random req.
  - Expect grant=0, owner=0, turn=0, busy=0, timeout=0, violation=0.
  - Release reset with req=4'b0000 → state stays FREE.
- **Single requester:** req=4'b0100 at edge 0 → grant=4'b0100 and owner=2 from cycle 1.
  - rel[2] pulse at edge 5 → grant=0 from cycle 6 and turn=3.
- **Contention / round-robin:** hold req=4'b1111 and have each owner pulse rel after 3 cycles.
  - Grant order must be 0,1,2,3,0.
  - Successive grants are separated by exactly 2 zero-grant cycles.
  - violation stays 0.
- **Watchdog:** MAX_HOLD=10; req[1] held high with no rel.
  - grant[1] is high for exactly 10 cycles, then timeout pulses for 1 cycle and turn=2.
  - With rel[1] sampled in the same cycle as hold_cnt=9 → no timeout.
- **Non-owner noise:** owner=0; pulse rel[3] and toggle req[2] during GRANTED.
  - grant stays 4'b0001.
  - Pending req[2] is granted after owner 0 releases.
- **Reset mid-grant:** assert reset_n=0 asynchronously while grant=4'b1000.
  - grant goes to 0 immediately.
  - After reset is released with req=4'b1000, grant=4'b1000 returns one cycle later and turn=0.

Source files
------------

// File: rtl/mutex_arbiter.sv
// Round-robin mutual-exclusion arbiter with a hold-time watchdog.
// At most one requester holds the shared resource at a time.
module mutex_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 200
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         rel,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [$clog2(N)-1:0] turn,
  output logic                 timeout,
  output logic                 violation
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0]   N_VAL      = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N-1);
  localparam logic [7:0]    HOLD_LIMIT = 8'(MAX_HOLD-1);

  typedef enum logic [1:0] {
    FREE,
    GRANTED,
    RELEASE
  } state_t;

  state_t          state, state_next;
  logic [7:0]      hold_cnt, hold_cnt_next;
  logic [N-1:0]    grant_next;
  logic [IW-1:0]   owner_next, turn_next;
  logic            busy_next, timeout_next, violation_next;
  logic [IW-1:0]   sel;
  logic            sel_valid;
  logic [IW:0]     probe;
  logic            release_cond;

  // First pending request at or above turn, wrapping modulo N.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    probe     = '0;
    for (int i = 0; i < N; i++) begin
      probe = {1'b0, turn} + (IW+1)'(i);
      if (probe >= N_VAL) probe = probe - N_VAL;
      if (!sel_valid && req[probe[IW-1:0]]) begin
        sel       = probe[IW-1:0];
        sel_valid = 1'b1;
      end
    end
  end

  assign release_cond = rel[owner] | ~req[owner];

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    owner_next    = owner;
    turn_next     = turn;
    hold_cnt_next = hold_cnt;
    timeout_next  = 1'b0;
    case (state)
      FREE: begin
        if (sel_valid) begin
          grant_next      = '0;
          grant_next[sel] = 1'b1;
          owner_next      = sel;
          hold_cnt_next   = '0;
          state_next      = GRANTED;
        end
      end
      GRANTED: begin
        if (hold_cnt != 8'hFF) hold_cnt_next = hold_cnt + 8'd1;
        // A voluntary release in the watchdog cycle suppresses the timeout pulse.
        if (release_cond || hold_cnt == HOLD_LIMIT) begin
          state_next   = RELEASE;
          grant_next   = '0;
          turn_next    = (owner == LAST_IDX) ? '0 : owner + IW'(1);
          timeout_next = ~release_cond;
        end
      end
      RELEASE: state_next = FREE;
      default: state_next = FREE;
    endcase
    busy_next      = |grant_next;
    violation_next = violation | ((grant_next & (grant_next - N'(1))) != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FREE;
      grant     <= '0;
      owner     <= '0;
      turn      <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      violation <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      owner     <= owner_next;
      turn      <= turn_next;
      busy      <= busy_next;
      timeout   <= timeout_next;
      violation <= violation_next;
      hold_cnt  <= hold_cnt_next;
    end
  end

endmodule
